// File: rtl/adc_timing_pkg.sv
// Shared types and default timing constants for the ADC conversion timing chain.
package adc_timing_pkg;

  localparam int CLK_FREQ_HZ           = 3276800;
  localparam int GRID_HZ               = 50;
  localparam int DEF_SAMPLES_PER_CYCLE = 64;
  localparam int DEF_CLOCK_DIV         = CLK_FREQ_HZ / GRID_HZ / DEF_SAMPLES_PER_CYCLE;
  localparam int DEF_CONVST_WIDTH      = 4;
  localparam int DEF_BUSY_TIMEOUT      = 256;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    WAIT_BUSY,
    HANDOFF
  } conv_state_t;

  typedef struct packed {
    logic overrun;
    logic timeout;
    logic resync;
  } err_flags_t;

endpackage

// File: rtl/sample_tick_scheduler.sv
// Turns the 50 Hz reference edge into SAMPLES_PER_CYCLE evenly spaced sample ticks
// and keeps the grid-cycle counter.
module sample_tick_scheduler
  import adc_timing_pkg::*;
#(
  parameter int CLOCK_DIV         = DEF_CLOCK_DIV,
  parameter int SAMPLES_PER_CYCLE = DEF_SAMPLES_PER_CYCLE,
  localparam int DIV_W = $clog2(CLOCK_DIV),
  localparam int CNT_W = $clog2(SAMPLES_PER_CYCLE + 1),
  localparam int IDX_W = $clog2(SAMPLES_PER_CYCLE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  output logic             tick,
  output logic [IDX_W-1:0] tick_idx,
  output logic [15:0]      tick_cycle,
  output logic             locked,
  output logic             resync
);

  logic             pulse_q;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] tick_cnt;
  logic [15:0]      cycle_id;
  logic             edge_det;
  logic             active;
  logic             div_tc;

  assign edge_det = pulse & ~pulse_q;
  assign active   = locked && (tick_cnt != CNT_W'(SAMPLES_PER_CYCLE));
  assign div_tc   = active && (div_cnt == DIV_W'(CLOCK_DIV - 1));
  assign tick     = edge_det | div_tc;
  assign resync   = edge_det & active;
  assign tick_idx = edge_det ? '0 : tick_cnt[IDX_W-1:0];
  // The edge tick belongs to the new cycle, so it carries the incremented ID.
  assign tick_cycle = (edge_det && locked) ? cycle_id + 16'd1 : cycle_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q  <= 1'b0;
      div_cnt  <= '0;
      tick_cnt <= '0;
      cycle_id <= '0;
      locked   <= 1'b0;
    end else begin
      pulse_q <= pulse;
      if (edge_det) begin
        div_cnt  <= '0;
        tick_cnt <= CNT_W'(1);
        locked   <= 1'b1;
        cycle_id <= tick_cycle;
      end else if (active) begin
        div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
        if (div_tc) tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: CONVST/BUSY handshake per sample tick, tagged
// valid/ready handoff to capture, sticky timing error flags.
module adc_conv_sequencer
  import adc_timing_pkg::*;
#(
  parameter int CLOCK_DIV         = DEF_CLOCK_DIV,
  parameter int SAMPLES_PER_CYCLE = DEF_SAMPLES_PER_CYCLE,
  parameter int CONVST_WIDTH      = DEF_CONVST_WIDTH,
  parameter int BUSY_TIMEOUT      = DEF_BUSY_TIMEOUT,
  localparam int IDX_W   = $clog2(SAMPLES_PER_CYCLE),
  localparam int TMR_MAX = (CONVST_WIDTH > BUSY_TIMEOUT) ? CONVST_WIDTH : BUSY_TIMEOUT,
  localparam int TMR_W   = $clog2(TMR_MAX + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             PULSE_50_HZ,
  input  logic             ADC_BUSY,
  input  logic             SAMPLE_READY,
  input  logic             CLR_ERR,
  output logic             CONVST,
  output logic             SAMPLE_VALID,
  output logic [IDX_W-1:0] SAMPLE_IDX,
  output logic [15:0]      CYCLE_ID,
  output logic             SYNC_LOCKED,
  output logic             ERR_OVERRUN,
  output logic             ERR_TIMEOUT,
  output logic             ERR_RESYNC
);

  logic             tick;
  logic [IDX_W-1:0] tick_idx;
  logic [15:0]      tick_cycle;
  logic             resync_evt;
  logic             busy_meta;
  logic             busy_s;
  conv_state_t      state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             seen, seen_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [15:0]      cid_nxt;
  err_flags_t       err, err_set;

  sample_tick_scheduler #(
    .CLOCK_DIV         (CLOCK_DIV),
    .SAMPLES_PER_CYCLE (SAMPLES_PER_CYCLE)
  ) u_sched (
    .clk        (CLK),
    .rst_n      (nRST),
    .pulse      (PULSE_50_HZ),
    .tick       (tick),
    .tick_idx   (tick_idx),
    .tick_cycle (tick_cycle),
    .locked     (SYNC_LOCKED),
    .resync     (resync_evt)
  );

  always_comb begin
    state_nxt      = state;
    tmr_nxt        = tmr;
    seen_nxt       = seen;
    idx_nxt        = SAMPLE_IDX;
    cid_nxt        = CYCLE_ID;
    err_set        = '0;
    err_set.resync = resync_evt;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = CONV;
          tmr_nxt   = TMR_W'(CONVST_WIDTH - 1);
          seen_nxt  = 1'b0;
          idx_nxt   = tick_idx;
          cid_nxt   = tick_cycle;
        end
      end
      CONV: begin
        if (busy_s) seen_nxt = 1'b1;
        if (tmr == '0) begin
          state_nxt = WAIT_BUSY;
          tmr_nxt   = TMR_W'(BUSY_TIMEOUT - 1);
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (busy_s) seen_nxt = 1'b1;
        if (seen && !busy_s) begin
          state_nxt = HANDOFF;
        end else if (tmr == '0) begin
          state_nxt       = IDLE;
          err_set.timeout = 1'b1;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      HANDOFF: begin
        if (SAMPLE_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A tick that finds the converter busy is lost; the schedule keeps running.
    if (tick && (state != IDLE)) err_set.overrun = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_meta    <= 1'b0;
      busy_s       <= 1'b0;
      state        <= IDLE;
      tmr          <= '0;
      seen         <= 1'b0;
      SAMPLE_IDX   <= '0;
      CYCLE_ID     <= '0;
      CONVST       <= 1'b0;
      SAMPLE_VALID <= 1'b0;
      err          <= '0;
    end else begin
      busy_meta    <= ADC_BUSY;
      busy_s       <= busy_meta;
      state        <= state_nxt;
      tmr          <= tmr_nxt;
      seen         <= seen_nxt;
      SAMPLE_IDX   <= idx_nxt;
      CYCLE_ID     <= cid_nxt;
      CONVST       <= (state_nxt == CONV);
      SAMPLE_VALID <= (state_nxt == HANDOFF);
      err          <= (CLR_ERR ? '0 : err) | err_set;
    end
  end

  assign ERR_OVERRUN = err.overrun;
  assign ERR_TIMEOUT = err.timeout;
  assign ERR_RESYNC  = err.resync;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer with a scaled-down schedule
// (512 clocks per tick, 16 ticks per grid cycle) and a simple ADC BUSY model.
module tb_adc_conv_sequencer;

  localparam int DIV      = 512;
  localparam int N        = 16;
  localparam int CW       = 4;
  localparam int TO       = 256;
  localparam int BUSY_LEN = 100;
  localparam int IW       = $clog2(N);

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          PULSE_50_HZ = 1'b0;
  logic          ADC_BUSY = 1'b0;
  logic          SAMPLE_READY = 1'b1;
  logic          CLR_ERR = 1'b0;
  logic          CONVST;
  logic          SAMPLE_VALID;
  logic [IW-1:0] SAMPLE_IDX;
  logic [15:0]   CYCLE_ID;
  logic          SYNC_LOCKED;
  logic          ERR_OVERRUN;
  logic          ERR_TIMEOUT;
  logic          ERR_RESYNC;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_q[$];
  int width_q[$];
  int xidx_q[$];
  int xcid_q[$];
  int wcnt = 0;
  logic convst_prev = 1'b0;
  logic adc_prev = 1'b0;
  int bcnt = 0;
  logic busy_stuck = 1'b0;
  int t0, t1, t2, t3, t4;

  adc_conv_sequencer #(
    .CLOCK_DIV         (DIV),
    .SAMPLES_PER_CYCLE (N),
    .CONVST_WIDTH      (CW),
    .BUSY_TIMEOUT      (TO)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .PULSE_50_HZ  (PULSE_50_HZ),
    .ADC_BUSY     (ADC_BUSY),
    .SAMPLE_READY (SAMPLE_READY),
    .CLR_ERR      (CLR_ERR),
    .CONVST       (CONVST),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_IDX   (SAMPLE_IDX),
    .CYCLE_ID     (CYCLE_ID),
    .SYNC_LOCKED  (SYNC_LOCKED),
    .ERR_OVERRUN  (ERR_OVERRUN),
    .ERR_TIMEOUT  (ERR_TIMEOUT),
    .ERR_RESYNC   (ERR_RESYNC)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: CONVST rise times/widths and accepted transfers.
  always @(negedge CLK) begin
    if (CONVST && !convst_prev) begin
      rise_q.push_back(cyc);
      wcnt = 0;
    end
    if (CONVST) wcnt++;
    if (!CONVST && convst_prev) width_q.push_back(wcnt);
    convst_prev = CONVST;
    if (SAMPLE_VALID && SAMPLE_READY) begin
      xidx_q.push_back(int'(SAMPLE_IDX));
      xcid_q.push_back(int'(CYCLE_ID));
    end
  end

  // ADC model: BUSY high for BUSY_LEN clocks after each CONVST rise, or stuck high.
  always @(negedge CLK) begin
    if (CONVST && !adc_prev) bcnt = BUSY_LEN;
    else if (bcnt > 0) bcnt--;
    adc_prev = CONVST;
    ADC_BUSY = busy_stuck || (bcnt > 0);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_at(input int t);
    wait_until(t);
    PULSE_50_HZ = 1'b1;
    wait_until(t + 10);
    PULSE_50_HZ = 1'b0;
  endtask

  task automatic clear_queues();
    rise_q.delete();
    width_q.delete();
    xidx_q.delete();
    xcid_q.delete();
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] outs_vec();
    return {CONVST, SAMPLE_VALID, SYNC_LOCKED, ERR_OVERRUN, ERR_TIMEOUT, ERR_RESYNC,
            10'(SAMPLE_IDX), CYCLE_ID};
  endfunction

  initial begin
    // Reset and idle without any pulse.
    wait_until(3);
    check("reset_outputs", outs_vec(), 32'd0);
    wait_until(5);
    nRST = 1'b1;
    wait_until(8);
    check("post_reset_outputs", outs_vec(), 32'd0);
    wait_until(3000);
    check("idle_no_convst", rise_q.size(), 0);
    check("idle_unlocked", SYNC_LOCKED, 1'b0);
    check("idle_outputs", outs_vec(), 32'd0);

    // Full grid cycle with READY held high.
    t0 = 3100;
    pulse_at(t0);
    check("locked_after_pulse", SYNC_LOCKED, 1'b1);
    t1 = t0 + N * DIV;
    wait_until(t1 - 5);
    check("cyc0_rise_count", rise_q.size(), N);
    for (int k = 0; k < rise_q.size(); k++)
      check($sformatf("cyc0_rise_%0d", k), rise_q[k], t0 + 1 + k * DIV);
    for (int k = 0; k < width_q.size(); k++)
      check($sformatf("cyc0_width_%0d", k), width_q[k], CW);
    check("cyc0_xfer_count", xidx_q.size(), N);
    for (int k = 0; k < xidx_q.size(); k++) begin
      check($sformatf("cyc0_idx_%0d", k), xidx_q[k], k);
      check($sformatf("cyc0_cid_%0d", k), xcid_q[k], 0);
    end
    check("cyc0_errors", {ERR_OVERRUN, ERR_TIMEOUT, ERR_RESYNC}, 3'b000);

    // Second cycle: READY low on sample 0 forces an overrun of tick 1.
    clear_queues();
    SAMPLE_READY = 1'b0;
    pulse_at(t1);
    wait_until(t1 + 300);
    check("stall_valid", SAMPLE_VALID, 1'b1);
    check("stall_idx", SAMPLE_IDX, 0);
    check("stall_cid", CYCLE_ID, 1);
    check("no_resync_on_boundary", ERR_RESYNC, 1'b0);
    check("no_overrun_yet", ERR_OVERRUN, 1'b0);
    wait_until(t1 + 600);
    check("stall_valid_held", SAMPLE_VALID, 1'b1);
    check("stall_idx_held", SAMPLE_IDX, 0);
    check("stall_cid_held", CYCLE_ID, 1);
    check("overrun_set", ERR_OVERRUN, 1'b1);
    wait_until(t1 + 700);
    SAMPLE_READY = 1'b1;
    wait_until(t1 + 1400);
    check("ovr_xfer_count", xidx_q.size(), 2);
    check("ovr_first_idx", q_at(xidx_q, 0), 0);
    check("ovr_next_idx", q_at(xidx_q, 1), 2);
    check("ovr_next_cid", q_at(xcid_q, 1), 1);

    // Third cycle: BUSY stuck high -> timeout, set wins over a concurrent clear.
    t2 = t1 + N * DIV;
    wait_until(t2 - 5);
    CLR_ERR = 1'b1;
    wait_until(t2 - 4);
    CLR_ERR = 1'b0;
    busy_stuck = 1'b1;
    clear_queues();
    wait_until(t2 - 2);
    check("overrun_cleared", ERR_OVERRUN, 1'b0);
    pulse_at(t2);
    check("to_rise", q_at(rise_q, 0), t2 + 1);
    wait_until(t2 + 250);
    CLR_ERR = 1'b1;
    wait_until(t2 + 260);
    check("timeout_not_early", ERR_TIMEOUT, 1'b0);
    wait_until(t2 + 261);
    check("timeout_set_wins", ERR_TIMEOUT, 1'b1);
    CLR_ERR = 1'b0;
    wait_until(t2 + 300);
    busy_stuck = 1'b0;
    wait_until(t2 + 400);
    check("timeout_no_valid", xidx_q.size(), 0);
    wait_until(t2 + 800);
    check("after_to_xfer_count", xidx_q.size(), 1);
    check("after_to_idx", q_at(xidx_q, 0), 1);
    check("after_to_cid", q_at(xcid_q, 0), 2);
    check("timeout_still_set", ERR_TIMEOUT, 1'b1);
    wait_until(t2 + 810);
    CLR_ERR = 1'b1;
    wait_until(t2 + 811);
    CLR_ERR = 1'b0;
    wait_until(t2 + 812);
    check("timeout_cleared", ERR_TIMEOUT, 1'b0);

    // Fourth cycle: early pulse between ticks 9 and 10 -> resync.
    t3 = t2 + N * DIV;
    pulse_at(t3);
    t4 = t3 + 5000;
    wait_until(t4 - 10);
    check("no_resync_before", ERR_RESYNC, 1'b0);
    clear_queues();
    pulse_at(t4);
    wait_until(t4 + 200);
    check("resync_set", ERR_RESYNC, 1'b1);
    check("resync_rise_count", rise_q.size(), 1);
    check("resync_rise", q_at(rise_q, 0), t4 + 1);
    check("resync_idx", q_at(xidx_q, 0), 0);
    check("resync_cid", q_at(xcid_q, 0), 4);
    check("resync_no_overrun", ERR_OVERRUN, 1'b0);

    // Asynchronous reset in the middle of CONV.
    wait_until(t4 + 514);
    check("conv_before_reset", CONVST, 1'b1);
    nRST = 1'b0;
    #1;
    check("async_convst_drop", CONVST, 1'b0);
    check("async_outputs", outs_vec(), 32'd0);
    wait_until(t4 + 520);
    nRST = 1'b1;
    clear_queues();
    wait_until(t4 + 520 + 2 * DIV + 50);
    check("post_reset_no_convst", rise_q.size(), 0);
    check("post_reset_unlocked", SYNC_LOCKED, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
